// File: rtl/mm_pkg.sv
// Shared constants, loader state encoding and a clog2 helper for the matrix multiplier
// subsystem. Used by the multiplier and by its stream front-end.
package mm_pkg;

   localparam int MM_DATA_WIDTH = 32'd8;
   localparam int MM_M          = 32'd8;
   localparam int MM_N          = 32'd8;
   localparam int MM_P          = 32'd8;

   localparam logic [1:0] ST_LOAD_A = 2'b00;
   localparam logic [1:0] ST_LOAD_B = 2'b01;
   localparam logic [1:0] ST_START  = 2'b10;
   localparam logic [1:0] ST_WAIT   = 2'b11;

   typedef enum logic [1:0] {
      S_LOAD_A = ST_LOAD_A,
      S_LOAD_B = ST_LOAD_B,
      S_START  = ST_START,
      S_WAIT   = ST_WAIT
   } loader_state_e;

   // Never returns less than 1 so a counter sized with it always has a bit.
   function automatic int mm_clog2(input int value);
      int result;
      result = 32'd1;
      while ((32'd1 << result) < value) begin
         result = result + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Stream input plus flat-matrix start/done bundle between the loader and its neighbours.
// The slave modport is the loader; the master modport is the stream source / multiplier side.
interface matrix_stream_loader_if
   import mm_pkg::*;
#(
   parameter int DATA_WIDTH = MM_DATA_WIDTH,
   parameter int M          = MM_M,
   parameter int N          = MM_N,
   parameter int P          = MM_P
);
   logic                         in_valid;
   logic                         in_ready;
   logic [DATA_WIDTH-1:0]        in_data;
   logic                         in_last;
   logic [M*N*DATA_WIDTH-1:0]    matrix_a;
   logic [N*P*DATA_WIDTH-1:0]    matrix_b;
   logic                         start;
   logic                         mul_done;
   logic                         busy;
   logic                         frame_err;

   modport master (
      output in_valid, in_data, in_last, mul_done,
      input  in_ready, matrix_a, matrix_b, start, busy, frame_err
   );

   modport slave (
      input  in_valid, in_data, in_last, mul_done,
      output in_ready, matrix_a, matrix_b, start, busy, frame_err
   );

endinterface

// File: rtl/matrix_stream_loader.sv
// Packs a serial A-then-B element stream into flat row-major buses, pulses start, and
// holds the buses until the multiplier reports done. Bad framing restarts the frame.
module matrix_stream_loader
   import mm_pkg::*;
#(
   parameter int DATA_WIDTH = MM_DATA_WIDTH,
   parameter int M          = MM_M,
   parameter int N          = MM_N,
   parameter int P          = MM_P
) (
   input logic                    clk,
   input logic                    rst_n,
   matrix_stream_loader_if.slave  bus
);

   localparam int A_ELEMS   = M * N;
   localparam int B_ELEMS   = N * P;
   localparam int MAX_ELEMS = (A_ELEMS > B_ELEMS) ? A_ELEMS : B_ELEMS;
   localparam int CNT_W     = mm_clog2(MAX_ELEMS);

   localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(A_ELEMS - 1);
   localparam logic [CNT_W-1:0] B_LAST   = CNT_W'(B_ELEMS - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   loader_state_e                state_r;
   loader_state_e                state_next_s;
   logic [CNT_W-1:0]             cnt_r;
   logic [CNT_W-1:0]             cnt_next_s;
   logic                         write_a_s;
   logic                         write_b_s;
   logic                         err_s;
   logic                         frame_err_r;
   logic [M*N*DATA_WIDTH-1:0]    matrix_a_r;
   logic [N*P*DATA_WIDTH-1:0]    matrix_b_r;

   // State and element counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_LOAD_A;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state, counter and write-enable decode; in the load states every valid beat is accepted.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      write_a_s    = 1'b0;
      write_b_s    = 1'b0;
      err_s        = 1'b0;
      case (state_r)
         S_LOAD_A: begin
            if (bus.in_valid) begin
               write_a_s = 1'b1;
               if (bus.in_last) begin
                  err_s        = 1'b1;
                  cnt_next_s   = CNT_ZERO;
                  state_next_s = S_LOAD_A;
               end else if (cnt_r == A_LAST) begin
                  cnt_next_s   = CNT_ZERO;
                  state_next_s = S_LOAD_B;
               end else begin
                  cnt_next_s   = cnt_r + CNT_ONE;
               end
            end else begin
               cnt_next_s = cnt_r;
            end
         end
         S_LOAD_B: begin
            if (bus.in_valid) begin
               write_b_s = 1'b1;
               if ((cnt_r == B_LAST) && bus.in_last) begin
                  state_next_s = S_START;
               end else if ((cnt_r == B_LAST) || bus.in_last) begin
                  err_s        = 1'b1;
                  cnt_next_s   = CNT_ZERO;
                  state_next_s = S_LOAD_A;
               end else begin
                  cnt_next_s   = cnt_r + CNT_ONE;
               end
            end else begin
               cnt_next_s = cnt_r;
            end
         end
         S_START: begin
            state_next_s = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mul_done) begin
               cnt_next_s   = CNT_ZERO;
               state_next_s = S_LOAD_A;
            end else begin
               state_next_s = S_WAIT;
            end
         end
         default: begin
            cnt_next_s   = CNT_ZERO;
            state_next_s = S_LOAD_A;
         end
      endcase
   end

   // Matrix buses: only the addressed element changes, and only on an accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         matrix_a_r <= '0;
         matrix_b_r <= '0;
      end else begin
         for (int e = 0; e < A_ELEMS; e++) begin
            if (write_a_s && (cnt_r == CNT_W'(e))) begin
               matrix_a_r[e*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
            end
         end
         for (int e = 0; e < B_ELEMS; e++) begin
            if (write_b_s && (cnt_r == CNT_W'(e))) begin
               matrix_b_r[e*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
            end
         end
      end
   end

   // Framing error pulse, one cycle after the offending beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_r <= 1'b0;
      end else begin
         frame_err_r <= err_s;
      end
   end

   assign bus.matrix_a  = matrix_a_r;
   assign bus.matrix_b  = matrix_b_r;
   assign bus.frame_err = frame_err_r;
   assign bus.in_ready  = (state_r == S_LOAD_A) || (state_r == S_LOAD_B);
   assign bus.start     = (state_r == S_START);
   assign bus.busy      = (state_r == S_START) || (state_r == S_WAIT);

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader with 2x2 matrices: directed frames from the test plan plus
// random traffic, each cycle compared against a frame-level reference model.
module tb_matrix_stream_loader;

   localparam int DW      = 8;
   localparam int A_ELEMS = 4;
   localparam int B_ELEMS = 4;
   localparam int F_ELEMS = A_ELEMS + B_ELEMS;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // Reference model: position within the frame, busy (start or waiting) and the stored elements.
   int           m_k;
   bit           m_busy;
   bit           m_start;
   logic [7:0]   m_a [A_ELEMS];
   logic [7:0]   m_b [B_ELEMS];

   matrix_stream_loader_if #(.DATA_WIDTH(DW), .M(2), .N(2), .P(2)) bus ();

   matrix_stream_loader #(.DATA_WIDTH(DW), .M(2), .N(2), .P(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_a();
      logic [31:0] v;
      for (int e = 0; e < A_ELEMS; e++) v[e*8 +: 8] = m_a[e];
      return v;
   endfunction

   function automatic logic [31:0] pack_b();
      logic [31:0] v;
      for (int e = 0; e < B_ELEMS; e++) v[e*8 +: 8] = m_b[e];
      return v;
   endfunction

   task automatic check_outputs(input bit exp_err);
      check_val("start",     64'(bus.start),     64'(m_start));
      check_val("busy",      64'(bus.busy),      64'(m_busy));
      check_val("in_ready",  64'(bus.in_ready),  64'(!m_busy));
      check_val("frame_err", 64'(bus.frame_err), 64'(exp_err));
      check_val("matrix_a",  64'(bus.matrix_a),  64'(pack_a()));
      check_val("matrix_b",  64'(bus.matrix_b),  64'(pack_b()));
   endtask

   task automatic model_reset();
      m_k     = 0;
      m_busy  = 1'b0;
      m_start = 1'b0;
      for (int e = 0; e < A_ELEMS; e++) m_a[e] = 8'h00;
      for (int e = 0; e < B_ELEMS; e++) m_b[e] = 8'h00;
   endtask

   // One clock: drive at negedge, advance the model over the rising edge, compare just after it.
   task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit dn);
      bit acc;
      bit exp_err;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_last  = l;
      bus.mul_done = dn;
      @(posedge clk);
      acc     = v && !m_busy;
      exp_err = 1'b0;
      if (m_start) begin
         m_start = 1'b0;
      end else if (m_busy) begin
         if (dn) m_busy = 1'b0;
      end else if (acc) begin
         if (m_k < A_ELEMS) m_a[m_k] = d;
         else               m_b[m_k - A_ELEMS] = d;
         if ((m_k == F_ELEMS - 1) && l) begin
            m_busy  = 1'b1;
            m_start = 1'b1;
            m_k     = 0;
         end else if (l || (m_k == F_ELEMS - 1)) begin
            exp_err = 1'b1;
            m_k     = 0;
         end else begin
            m_k = m_k + 1;
         end
      end
      #1;
      check_outputs(exp_err);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.mul_done = 1'b0;
      #1;
      model_reset();
      check_outputs(1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Sends len beats base, base+1, ...; in_last on index last_at (-1 for none).
   task automatic send_frame(input logic [7:0] base, input int len, input int last_at, input bit gaps);
      for (int i = 0; i < len; i++) begin
         cyc(1'b1, base + 8'(i), (i == last_at), 1'b0);
         if (gaps) cyc(1'b0, 8'hEE, 1'b1, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic done_pulse();
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      bus.mul_done = 1'b0;
      model_reset();

      apply_reset();

      // Nominal frame; mul_done before the start cycle must be ignored.
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      send_frame(8'h01, 8, 7, 1'b0);
      idle(3);
      check_val("nominal_a", 64'(bus.matrix_a), 64'h04030201);
      check_val("nominal_b", 64'(bus.matrix_b), 64'h08070605);

      // Backpressure in wait, then 9 lands in A[0].
      for (int i = 0; i < 20; i++) cyc(1'b1, 8'h09, 1'b0, 1'b0);
      cyc(1'b1, 8'h09, 1'b0, 1'b1);
      cyc(1'b1, 8'h09, 1'b0, 1'b0);
      check_val("bp_a", 64'(bus.matrix_a), 64'h04030209);
      for (int i = 1; i < F_ELEMS; i++) cyc(1'b1, 8'(i + 1), (i == F_ELEMS - 1), 1'b0);
      idle(2);
      done_pulse();

      // Bubbles between beats.
      send_frame(8'h01, 8, 7, 1'b1);
      idle(2);
      check_val("bubble_a", 64'(bus.matrix_a), 64'h04030201);
      done_pulse();

      // Early last on A[2], then a clean frame 10..17.
      send_frame(8'h01, 3, 2, 1'b0);
      idle(1);
      send_frame(8'h0A, 8, 7, 1'b0);
      idle(1);
      check_val("early_b", 64'(bus.matrix_b), 64'h11100F0E);
      done_pulse();

      // Missing last.
      send_frame(8'h01, 8, -1, 1'b0);
      idle(2);

      // Reset in the middle of B, then a full frame.
      send_frame(8'h20, 6, -1, 1'b0);
      apply_reset();
      send_frame(8'h30, 8, 7, 1'b0);
      idle(2);
      check_val("post_rst_b", 64'(bus.matrix_b), 64'h37363534);
      done_pulse();

      // Random traffic; in_last is likely on the frame's final element and rare elsewhere.
      for (int i = 0; i < 600; i++) begin
         bit          v;
         bit          l;
         bit          dn;
         logic [7:0]  d;
         v  = ($urandom_range(0, 3) != 0);
         d  = 8'($urandom);
         if (m_k == F_ELEMS - 1) l = ($urandom_range(0, 7) != 0);
         else                    l = ($urandom_range(0, 24) == 0);
         dn = ($urandom_range(0, 3) == 0);
         cyc(v, d, l, dn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
